// File: rtl/regfile_param_clr.sv
// Parametrised register file: two registered read ports, one write port,
// optional hardwired-zero entry and write-to-read bypass, and a one-entry-per-cycle bulk clear.
module regfile_param_clr #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1,
    input  logic [ADDR_W-1:0] read2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              RegWrite,
    input  logic              clear,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              write_ok;
    logic [DATA_W-1:0] rd1_p0, rd2_p0;

    // Read resolution, highest priority first: sweep, zero entry, bypass, array.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic              sweeping,
        input logic [ADDR_W-1:0] addr,
        input logic              wr_ok,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        if (sweeping)
            return '0;
        else if ((ZERO_REG != 0) && (addr == '0))
            return '0;
        else if ((BYPASS != 0) && wr_ok && (wr_addr == addr))
            return wr_data;
        else
            return stored;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear) state_nxt = CLEAR;
            CLEAR:   if (ptr == '1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    // Writes are blocked during the sweep; a dropped zero-entry write must not bypass either.
    assign write_ok = (state == IDLE) && RegWrite && !((ZERO_REG != 0) && (write_reg == '0));

    always_ff @(posedge clk) begin
        if (!rst)
            ptr <= '0;
        else if (state == CLEAR)
            ptr <= ptr + 1'b1;
        else
            ptr <= '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (write_ok) begin
            mem[write_reg] <= write_data;
        end
    end

    always_comb begin
        rd1_p0 = read_sel(busy, read1, write_ok, write_reg, write_data, mem[read1]);
        rd2_p0 = read_sel(busy, read2, write_ok, write_reg, write_data, mem[read2]);
    end

    // p0 -> registered read outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            data1 <= '0;
            data2 <= '0;
        end else begin
            data1 <= rd1_p0;
            data2 <= rd2_p0;
        end
    end

endmodule

// File: tb/tb_regfile_param_clr.sv
// Bench for regfile_param_clr: default configuration plus a ZERO_REG=0/BYPASS=0 copy on shared inputs.
module tb_regfile_param_clr;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic [AW-1:0] read1 = '0, read2 = '0, write_reg = '0;
    logic [DW-1:0] write_data = '0;
    logic          RegWrite = 1'b0, clear = 1'b0;
    logic [DW-1:0] a_d1, a_d2, b_d1, b_d2;
    logic          a_busy, b_busy;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_param_clr dut_a (
        .clk(clk), .rst(rst), .read1(read1), .read2(read2), .write_reg(write_reg),
        .write_data(write_data), .RegWrite(RegWrite), .clear(clear),
        .data1(a_d1), .data2(a_d2), .busy(a_busy)
    );

    regfile_param_clr #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .read1(read1), .read2(read2), .write_reg(write_reg),
        .write_data(write_data), .RegWrite(RegWrite), .clear(clear),
        .data1(b_d1), .data2(b_d2), .busy(b_busy)
    );

    // Model: index 0 = zero-entry + bypass configuration, index 1 = plain configuration.
    logic [DW-1:0] mmem [2][DEPTH];
    logic [DW-1:0] e_d1 [2];
    logic [DW-1:0] e_d2 [2];
    logic          e_busy = 1'b0;
    int            sweep_left = 0;
    bit            armed = 1'b0;

    function automatic logic [DW-1:0] model_read(input int c, input logic [AW-1:0] a);
        bit zr = (c == 0);
        bit byp = (c == 0);
        if (sweep_left > 0) return '0;
        if (zr && a == 0) return '0;
        if (byp && RegWrite && write_reg == a && !(zr && write_reg == 0)) return write_data;
        return mmem[c][a];
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < DEPTH; i++) mmem[c][i] = '0;
                e_d1[c] = '0;
                e_d2[c] = '0;
            end
            sweep_left = 0;
            armed = 1'b1;
        end else begin
            for (int c = 0; c < 2; c++) begin
                e_d1[c] = model_read(c, read1);
                e_d2[c] = model_read(c, read2);
            end
            if (sweep_left > 0) begin
                for (int c = 0; c < 2; c++) mmem[c][DEPTH - sweep_left] = '0;
                sweep_left--;
            end else begin
                if (RegWrite)
                    for (int c = 0; c < 2; c++)
                        if (!(c == 0 && write_reg == 0)) mmem[c][write_reg] = write_data;
                if (clear) sweep_left = DEPTH;
            end
        end
        e_busy = (sweep_left > 0);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("a_data1", a_d1, e_d1[0]);
            chk("a_data2", a_d2, e_d2[0]);
            chk("a_busy", {31'b0, a_busy}, {31'b0, e_busy});
            chk("b_data1", b_d1, e_d1[1]);
            chk("b_data2", b_d2, e_d2[1]);
            chk("b_busy", {31'b0, b_busy}, {31'b0, e_busy});
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        step(2);
        chk("rst_data1", a_d1, 32'h0);
        chk("rst_busy", {31'b0, a_busy}, 32'h0);
        rst = 1'b1;

        // write then read
        RegWrite = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
        step();
        RegWrite = 1'b0; read1 = 5'd5;
        step();
        chk("wr_rd_a", a_d1, 32'hDEADBEEF);
        chk("wr_rd_b", b_d1, 32'hDEADBEEF);

        // same-edge bypass
        RegWrite = 1'b1; write_reg = 5'd7; write_data = 32'h12345678; read1 = 5'd7; read2 = 5'd7;
        step();
        chk("byp_a1", a_d1, 32'h12345678);
        chk("byp_a2", a_d2, 32'h12345678);
        chk("nobyp_b1", b_d1, 32'h0);
        RegWrite = 1'b0;
        step();
        chk("after_byp_b1", b_d1, 32'h12345678);

        // zero entry
        RegWrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF; read1 = 5'd0;
        step();
        RegWrite = 1'b0;
        step();
        chk("zero_a", a_d1, 32'h0);
        chk("zero_b", b_d1, 32'hFFFFFFFF);

        // fill r1..r31 with their index
        for (int i = 1; i < DEPTH; i++) begin
            RegWrite = 1'b1; write_reg = AW'(i); write_data = DW'(i);
            step();
        end
        RegWrite = 1'b0; read1 = 5'd17; read2 = 5'd31;
        step();
        chk("fill_17", a_d1, 32'd17);
        chk("fill_31", a_d2, 32'd31);

        // clear at edge N together with a write to r3
        clear = 1'b1; RegWrite = 1'b1; write_reg = 5'd3; write_data = 32'hA5A5A5A5;
        step();
        chk("clr_busy_N", {31'b0, a_busy}, 32'h1);
        clear = 1'b0; RegWrite = 1'b0; read1 = 5'd5; read2 = 5'd3;
        for (int k = 1; k < DEPTH; k++) begin
            if (k == 10) begin
                clear = 1'b1; RegWrite = 1'b1; write_reg = 5'd9; write_data = 32'h99999999;
            end else if (k == 12) begin
                clear = 1'b0; RegWrite = 1'b0;
            end
            step();
            chk("clr_busy_mid", {31'b0, a_busy}, 32'h1);
            if (k == 5) chk("clr_forced0", a_d1, 32'h0);
        end
        step();
        chk("clr_busy_end", {31'b0, a_busy}, 32'h0);
        read1 = 5'd3; read2 = 5'd9;
        step();
        chk("clr_r3", a_d1, 32'h0);
        chk("clr_r9_lost", a_d2, 32'h0);
        read1 = 5'd31; read2 = 5'd0;
        step();
        chk("clr_r31", a_d1, 32'h0);
        chk("clr_b_r0", b_d2, 32'h0);

        // reset in the middle of a sweep
        RegWrite = 1'b1; write_reg = 5'd20; write_data = 32'h20202020; read1 = 5'd20; read2 = 5'd20;
        step();
        RegWrite = 1'b0;
        step();
        chk("r20_set", a_d1, 32'h20202020);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step(9);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_busy", {31'b0, a_busy}, 32'h0);
        chk("midrst_d1", a_d1, 32'h0);
        chk("midrst_d2", a_d2, 32'h0);
        step();
        chk("midrst_r20", a_d1, 32'h0);

        // normal writes resume after reset
        RegWrite = 1'b1; write_reg = 5'd4; write_data = 32'h44444444; read1 = 5'd4;
        step();
        RegWrite = 1'b0;
        step();
        chk("post_wr_a", a_d1, 32'h44444444);
        chk("post_wr_b", b_d1, 32'h44444444);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
